// File: rtl/tt_um_delta_decoder_pkg.sv
// Shared constants and types for the delta decoder: uio bit map, oe mask,
// decoder state encoding and default queue depth.
package tt_delta_pkg;
  localparam int IN_VALID  = 0;
  localparam int LOAD      = 1;
  localparam int OUT_READY = 2;
  localparam int IN_READY  = 4;
  localparam int OUT_VALID = 5;
  localparam int OVF       = 6;
  localparam int SEEDED    = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;
  localparam int DEFAULT_FIFO_DEPTH  = 4;

  typedef enum logic {UNSEEDED, RUN} dec_state_t;
endpackage

// File: rtl/tt_um_delta_decoder_if.sv
// Tiny Tapeout pin bundle: data inputs, bidir handshake pins and outputs.
interface tt_delta_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_delta_decoder_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers; storage is intentionally unreset,
// the consumer masks dout while empty.
module delta_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  // Same index bits with opposite wrap bits means the writer lapped the reader.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/tt_um_delta_decoder.sv
// Delta decoder top: seed/delta accumulator, seeding FSM, sticky wrap flag,
// output queue and Tiny Tapeout pin packing.
module tt_um_delta_decoder
  import tt_delta_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  tt_delta_if.slave  bus
);
  dec_state_t state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic       ovf_q, ovf_d;
  logic       push, pop, full, empty;
  logic       in_ready, out_valid, acc_fire;
  logic [7:0] push_data, fifo_dout;
  logic [9:0] sum_w;

  logic in_valid, load, out_ready;
  assign in_valid  = bus.uio_in[IN_VALID];
  assign load      = bus.uio_in[LOAD];
  assign out_ready = bus.uio_in[OUT_READY];

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.uio_in[7:3]};

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign acc_fire  = ena & in_valid & in_ready;
  assign pop       = ena & out_valid & out_ready;

  // 10-bit signed view: any bit above 7 set means the true sum left 0..255.
  assign sum_w = {2'b00, acc_q} + {{2{bus.ui_in[7]}}, bus.ui_in};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_data = bus.ui_in;
    if (acc_fire) begin
      if (load) begin
        acc_d   = bus.ui_in;
        ovf_d   = 1'b0;
        push    = 1'b1;
        state_d = RUN;
      end else if (state_q == RUN) begin
        acc_d     = sum_w[7:0];
        push_data = sum_w[7:0];
        push      = 1'b1;
        if (sum_w[9:8] != 2'b00) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNSEEDED;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  delta_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign bus.uo_out  = empty ? 8'h00 : fifo_dout;
  assign bus.uio_out = {(state_q == RUN), ovf_q, out_valid, in_ready, 4'b0000};
  assign bus.uio_oe  = UIO_OE_MASK;
endmodule

// File: tb/tb_tt_um_delta_decoder.sv
// Directed plus randomized check of the delta decoder against a queue-based
// reference model of the decode rules.
module tb_tt_um_delta_decoder;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;

  tt_delta_if bus ();

  tt_um_delta_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int  m_acc;
  bit  m_seeded, m_ovf;
  byte unsigned m_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e_uio;
    logic [7:0] e_uo;
    e_uo = (m_q.size() > 0) ? m_q[0] : 8'h00;
    e_uio = 8'h00;
    e_uio[7] = m_seeded;
    e_uio[6] = m_ovf;
    e_uio[5] = (m_q.size() > 0);
    e_uio[4] = (m_q.size() < DEPTH);
    chk({tag, "_uo"},  bus.uo_out,  e_uo);
    chk({tag, "_uio"}, bus.uio_out, e_uio);
    chk({tag, "_oe"},  bus.uio_oe,  8'hF0);
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_seeded = 0;
    m_ovf = 0;
    m_q.delete();
  endtask

  // One clock of the reference behaviour, from pre-edge state and inputs.
  task automatic model_edge(input logic [7:0] ui, input logic v, ld, rdy, en);
    bit fire, popv;
    int d, s;
    fire = en && v && (m_q.size() < DEPTH);
    popv = en && rdy && (m_q.size() > 0);
    if (popv) void'(m_q.pop_front());
    if (fire) begin
      if (ld) begin
        m_acc = ui;
        m_seeded = 1;
        m_ovf = 0;
        m_q.push_back(ui);
      end else if (m_seeded) begin
        d = (ui >= 128) ? int'(ui) - 256 : int'(ui);
        s = m_acc + d;
        if (s < 0 || s > 255) m_ovf = 1;
        m_acc = (s + 256) % 256;
        m_q.push_back(byte'(m_acc));
      end
    end
  endtask

  task automatic step(input string tag, input logic [7:0] ui, input logic v, ld, rdy, en);
    bus.ui_in  = ui;
    bus.uio_in = {5'b00000, rdy, ld, v};
    ena = en;
    model_edge(ui, v, ld, rdy, en);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    bus.uio_in = 8'h00;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("reset_idle");

    // basic decode with consumer always ready
    step("basic_ld", 8'h10, 1, 1, 1, 1);
    chk("basic_0x10", bus.uo_out, 8'h10);
    step("basic_d1", 8'h05, 1, 0, 1, 1);
    chk("basic_0x15", bus.uo_out, 8'h15);
    step("basic_d2", 8'hFD, 1, 0, 1, 1);
    chk("basic_0x12", bus.uo_out, 8'h12);
    step("basic_drain", 8'h00, 0, 0, 1, 1);

    // delta before seed is swallowed
    async_reset("rst2");
    step("preseed", 8'h07, 1, 0, 1, 1);
    chk("preseed_uio", bus.uio_out, 8'h10);
    step("preseed_ld", 8'h20, 1, 1, 1, 1);
    chk("preseed_0x20", bus.uo_out, 8'h20);
    step("preseed_drain", 8'h00, 0, 0, 1, 1);

    // unsigned wrap raises sticky overflow, load clears it
    step("wrap_ld", 8'hFE, 1, 1, 1, 1);
    step("wrap_d", 8'h05, 1, 0, 1, 1);
    chk("wrap_0x03", bus.uo_out, 8'h03);
    chk("wrap_ovf", {7'd0, bus.uio_out[6]}, 8'h01);
    step("wrap_d2", 8'h01, 1, 0, 1, 1);
    chk("wrap_0x04", bus.uo_out, 8'h04);
    step("wrap_ld0", 8'h00, 1, 1, 1, 1);
    chk("wrap_clr", {7'd0, bus.uio_out[6]}, 8'h00);
    step("wrap_drain", 8'h00, 0, 0, 1, 1);

    // backpressure: fill, hold, then drain with one push/pop overlap
    step("bp_ld", 8'h01, 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) step("bp_d", 8'h01, 1, 0, 0, 1);
    chk("bp_full_rdy", {7'd0, bus.uio_out[4]}, 8'h00);
    step("bp_pop1", 8'h01, 1, 0, 1, 1);
    step("bp_pushpop", 8'h01, 1, 0, 1, 1);
    chk("bp_0x03", bus.uo_out, 8'h03);
    for (int i = 0; i < 4; i++) step("bp_drain", 8'h00, 0, 0, 1, 1);

    // ena low freezes everything, then async reset with samples queued
    step("ena_ld", 8'h40, 1, 1, 0, 1);
    step("ena_d1", 8'h02, 1, 0, 0, 1);
    step("ena_d2", 8'h02, 1, 0, 0, 1);
    step("ena_off", 8'h09, 1, 0, 1, 0);
    step("ena_off2", 8'h09, 1, 1, 1, 0);
    chk("ena_head", bus.uo_out, 8'h40);
    async_reset("rst_mid");
    step("post_rst_d", 8'h03, 1, 0, 1, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 96) async_reset("rnd_rst");
      else step("rnd", 8'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 9) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tt_um_delta_decoder.md
# tt_um_delta_decoder

Tiny Tapeout user project that reconstructs an 8-bit sample stream from mod-256 differences, the receive side of our difference datapath (`uo_out = a - b`). The decoder loads an absolute seed, then accumulates signed deltas presented on the dedicated inputs. It queues reconstructed samples in a small FIFO and presents them on the dedicated outputs under a valid/ready handshake carried on the bidirectional pins.

## Interface
- `FIFO_DEPTH`, default 4: output queue depth; must be a power of two, minimum 2.
- `clk`  input  1  single clock for all state.
- `rst_n`  input  1  asynchronous, active-low reset.
- `ena`  input  1  design enable; when low, no transfer is accepted and all state holds.
- `ui_in`  input  8  seed value (load=1) or two's-complement delta (load=0).
- `uio_in`  input  8  `[0]` in_valid; `[1]` load; `[2]` out_ready; `[7:3]` ignored.
- `uo_out`  output  8  FIFO head sample; 0 when the FIFO is empty.
- `uio_out`  output  8  `[3:0]` always 0; `[4]` in_ready; `[5]` out_valid; `[6]` overflow (sticky); `[7]` seeded.
- `uio_oe`  output  8  constant `8'hF0`.

## Operation
- Input accept: `acc_fire = ena & in_valid & in_ready`.
- `in_ready = !full`. It has no combinational path from out_ready.
- Output pop: `pop = ena & out_valid & out_ready`.
- `out_valid = !empty`.
- State machine, states UNSEEDED and RUN:
  - Reset enters UNSEEDED.
  - In UNSEEDED, a delta fire (load=0) is accepted and discarded: no push, acc unchanged.
  - A load fire in either state sets `acc <= ui_in`, pushes `ui_in`, clears overflow, and moves to RUN.
  - In RUN, a delta fire computes `acc_next = acc + ui_in` mod 256, updates acc, and pushes acc_next.
- seeded (`uio_out[7]`) = state is RUN.
- Overflow:
  - Set on a RUN delta fire when `{1'b0,acc} + sign_extend(ui_in)` lies outside 0..255, i.e. unsigned wrap.
  - Sticky until reset or the next load.
  - Wrap is not an error: the sample is still pushed as the mod-256 result.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits plus one extra wrap bit.
  - Full when the pointers differ only in the MSB; empty when they are equal.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - Push while full cannot occur, because in_ready is low.
- Reset values (asynchronous, immediate):
  - acc=0, state=UNSEEDED, pointers=0, overflow=0.
  - Outputs: `uo_out=0`, `uio_out=8'h10` (only in_ready high), `uio_oe=8'hF0`.
  - FIFO storage needs no reset; uo_out is masked to 0 while empty.
- Reset mid-operation discards queued samples and the seed. The next delta is dropped until a new load.

## Timing
- All inputs are sampled on the rising edge of clk. Drivers are synchronous to clk; no synchronizers are included.
- Latency: a fire at edge N with the FIFO empty gives out_valid=1 and uo_out equal to the sample after edge N. This is one cycle.
- A pop at edge N exposes the next entry (or 0 with out_valid=0) after edge N.
- in_ready falls after the edge that fills the FIFO. It rises after the first pop from full.
- Sustained throughput is one sample per cycle with out_ready held high.
- With ena low, fire and pop are both suppressed and registers hold. Outputs continue to reflect the held state.

## Structure
- Package `tt_delta_pkg`:
  - uio bit-index constants (`IN_VALID=0`, `LOAD=1`, `OUT_READY=2`, `IN_READY=4`, `OUT_VALID=5`, `OVF=6`, `SEEDED=7`).
  - `UIO_OE_MASK = 8'hF0`.
  - State enum `dec_state_t {UNSEEDED, RUN}`.
  - `DEFAULT_FIFO_DEPTH = 4`.
- Sub-module `delta_fifo` (parameterised width/depth):
  - Ports: push, pop, din, dout, full, empty.
  - Same clk/rst_n conventions.
- Top level contains the accumulator, the FSM, the overflow logic and the pin packing.

## Test plan
- Reset with ena=1, no stimulus -> uo_out=0x00, uio_out=0x10, uio_oe=0xF0.
- Basic decode, out_ready=1: load 0x10, then deltas 0x05 and 0xFD on consecutive cycles.
  - uo_out shows 0x10, 0x15, 0x12 on successive cycles.
  - seeded=1, overflow=0.
- Delta before seed: delta 0x07 with load=0 from reset -> accepted (in_ready=1), out_valid stays 0, seeded=0.
  - A following load of 0x20 outputs 0x20.
- Wrap: load 0xFE, then delta 0x05 -> output 0x03, overflow=1.
  - Delta 0x01 -> 0x04, overflow still 1.
  - Load 0x00 -> overflow=0.
- Backpressure, out_ready=0: load 0x01, then deltas 0x01 x4.
  - After 4 pushes in_ready=0 and the 5th input is held.
  - Raising out_ready drains 0x01, 0x02, 0x03, 0x04, then 0x05.
  - Simultaneous push/pop at full-1 keeps the count constant.
- ena/reset mid-stream: ena=0 with in_valid and out_ready high leaves uo_out and the pointers unchanged.
  - Then assert rst_n=0 with 3 samples queued: out_valid=0 and seeded=0 immediately, with no clock edge.
